calc_ndig: RTL and testbench

Parametrised successor of the team's decimal keypad calculator. It accepts 4-bit keypad commands under a valid/ready handshake and builds two decimal operands of up to NDIG digits. It performs add, subtract, multiply and optional divide, and chains results into the next operation. Every accepted command is followed by a serial scan of the current value onto the digit bus, least significant digit first.

---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_digit_scan.sv | 49 ++++
 rtl/calc_ndig.sv | 277 +++++++++++++++++++++++++++
 tb/tb_calc_ndig.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the N-digit decimal keypad calculator.
// Contents: keypad command codes, status codes, the controller state enum
// and a power-of-ten helper used to size the digit and overflow limits.
package calc_pkg;

    // Keypad command codes; 4'd0..4'd9 are digits.
    localparam logic [3:0] CMD_ADD  = 4'b1010;
    localparam logic [3:0] CMD_SUB  = 4'b1011;
    localparam logic [3:0] CMD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_DIV  = 4'b1101;
    localparam logic [3:0] CMD_EQ   = 4'b1110;
    localparam logic [3:0] CMD_BKSP = 4'b1111;

    // Status codes.
    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        CALC    = 3'd2,
        SHOW    = 3'd3,
        HOLD    = 3'd4,
        ERRO    = 3'd5
    } state_t;

    // 10**n, evaluated at elaboration time for the limit constants.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_digit_scan.sv
// calc_digit_scan: serialises a binary value as NDIG BCD digits, LSD first.
// Ports: load/value start a scan; data/pos/disp_valid carry one digit per
// cycle starting the cycle after load; done is high during the last digit.
module calc_digit_scan #(
    parameter int NDIG  = 8,
    parameter int WIDTH = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WIDTH-1:0]        value,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic                    disp_valid,
    output logic                    done
);

    localparam int              PW   = $clog2(NDIG);
    localparam logic [WIDTH-1:0] TEN  = WIDTH'(10);
    localparam logic [PW-1:0]    LAST = PW'(NDIG - 1);

    // Remaining value still to be emitted (already divided by 10 per digit).
    logic [WIDTH-1:0] rest;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rest       <= '0;
            data       <= '0;
            pos        <= '0;
            disp_valid <= 1'b0;
        end else if (load) begin
            data       <= 4'(value % TEN);
            rest       <= value / TEN;
            pos        <= '0;
            disp_valid <= 1'b1;
        end else if (disp_valid) begin
            if (pos == LAST) begin
                disp_valid <= 1'b0;
            end else begin
                data <= 4'(rest % TEN);
                rest <= rest / TEN;
                pos  <= pos + PW'(1);
            end
        end
    end

    assign done = disp_valid && (pos == LAST);

endmodule

// File: rtl/calc_ndig.sv
// calc_ndig: NDIG-digit decimal keypad calculator with result chaining.
// Ports: cmd/cmd_valid keypad input (taken while status=ready); status,
// EA debug state; data/pos/disp_valid serial digit scan after every command.
// Build option: define CALC_DIV_EN to include the divide datapath; without
// it the divide key is an invalid operator and forces the error state.
module calc_ndig
    import calc_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int WIDTH = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              cmd,
    input  logic                    cmd_valid,
    output logic [1:0]              status,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic                    disp_valid,
    output logic [2:0]              EA
);

    localparam logic [WIDTH-1:0] TEN  = WIDTH'(10);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    // Largest displayable value and the threshold at which entry is full.
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(pow10(NDIG) - 1);
    localparam logic [WIDTH-1:0] LIMV = WIDTH'(pow10(NDIG - 1));

    state_t           state, state_nxt;
    state_t           ret, ret_nxt;          // where SHOW returns to
    logic [WIDTH-1:0] cur, cur_nxt;          // operand being typed
    logic [WIDTH-1:0] a_reg, a_nxt;
    logic [WIDTH-1:0] b_reg, b_nxt;          // B, or the addend during mul
    logic [WIDTH-1:0] acc, acc_nxt;          // result / mul sum / div remainder
    logic [WIDTH-1:0] cnt, cnt_nxt;          // mul countdown / div quotient
    logic [WIDTH-1:0] shown, shown_nxt;      // value the next scan displays
    logic [3:0]       op, op_nxt;

    logic             accept;
    logic             is_digit;
    logic             is_op;
    logic             op_ok;
    logic             go_show;
    logic             go_err;
    logic [WIDTH-1:0] show_val;
    state_t           show_ret;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] cmd_w;
    logic             scan_load;
    logic             scan_done;

    assign cmd_w    = {{(WIDTH-4){1'b0}}, cmd};
    assign is_digit = (cmd <= 4'd9);
    assign is_op    = (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
                      (cmd == CMD_MUL) || (cmd == CMD_DIV);
`ifdef CALC_DIV_EN
    assign op_ok    = is_op;
`else
    assign op_ok    = is_op && (cmd != CMD_DIV);
`endif
    assign accept   = cmd_valid && (status == ST_READY);
    assign EA       = state;

    always_comb begin
        status = ST_BUSY;
        case (state)
            ENTER_A, ENTER_B, HOLD: status = ST_READY;
            ERRO:                   status = ST_ERR;
            default:                status = ST_BUSY;
        endcase
    end

    // The first SHOW cycle has no digit on the bus yet, which is when the
    // scanner is loaded; this gives the one idle busy cycle before digit 0.
    assign scan_load = (state == SHOW) && !disp_valid;

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret;
        cur_nxt   = cur;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        op_nxt    = op;
        shown_nxt = shown;
        go_show   = 1'b0;
        go_err    = 1'b0;
        show_val  = cur;
        show_ret  = state;
        sum       = '0;

        case (state)
            ENTER_A, ENTER_B: begin
                if (accept) begin
                    if (is_digit) begin
                        // A full entry swallows further digits unchanged.
                        if (cur < LIMV) cur_nxt = cur * TEN + cmd_w;
                        show_val = cur_nxt;
                        go_show  = 1'b1;
                    end else if (cmd == CMD_BKSP) begin
                        cur_nxt  = cur / TEN;
                        show_val = cur_nxt;
                        go_show  = 1'b1;
                    end else if (cmd == CMD_EQ) begin
                        if (state == ENTER_A) begin
                            go_show = 1'b1;
                        end else begin
                            b_nxt     = cur;
                            acc_nxt   = '0;
                            cnt_nxt   = '0;
                            state_nxt = CALC;
                            if (op == CMD_MUL) begin
                                // Loop over the smaller operand.
                                cnt_nxt = (a_reg < cur) ? a_reg : cur;
                                b_nxt   = (a_reg < cur) ? cur : a_reg;
                            end else if (op == CMD_DIV) begin
                                acc_nxt = a_reg;
                            end
                        end
                    end else if (!op_ok) begin
                        go_err = 1'b1;
                    end else if (state == ENTER_A) begin
                        a_nxt    = cur;
                        cur_nxt  = '0;
                        op_nxt   = cmd;
                        show_val = '0;
                        show_ret = ENTER_B;
                        go_show  = 1'b1;
                    end else if (cur == '0) begin
                        // B not started yet: the operator is just replaced.
                        op_nxt   = cmd;
                        show_val = '0;
                        go_show  = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end

            CALC: begin
                show_ret = HOLD;
                case (op)
                    CMD_ADD: begin
                        sum = {1'b0, a_reg} + {1'b0, b_reg};
                        if (sum > {1'b0, MAXV}) begin
                            go_err = 1'b1;
                        end else begin
                            acc_nxt  = sum[WIDTH-1:0];
                            show_val = sum[WIDTH-1:0];
                            go_show  = 1'b1;
                        end
                    end
                    CMD_SUB: begin
                        if (a_reg < b_reg) begin
                            go_err = 1'b1;
                        end else begin
                            acc_nxt  = a_reg - b_reg;
                            show_val = a_reg - b_reg;
                            go_show  = 1'b1;
                        end
                    end
                    CMD_MUL: begin
                        if (cnt == '0) begin
                            show_val = acc;
                            go_show  = 1'b1;
                        end else begin
                            sum = {1'b0, acc} + {1'b0, b_reg};
                            if (sum > {1'b0, MAXV}) begin
                                go_err = 1'b1;
                            end else begin
                                acc_nxt = sum[WIDTH-1:0];
                                cnt_nxt = cnt - ONE;
                            end
                        end
                    end
`ifdef CALC_DIV_EN
                    CMD_DIV: begin
                        if (b_reg == '0) begin
                            go_err = 1'b1;
                        end else if (acc >= b_reg) begin
                            acc_nxt = acc - b_reg;
                            cnt_nxt = cnt + ONE;
                        end else begin
                            acc_nxt  = cnt;
                            show_val = cnt;
                            go_show  = 1'b1;
                        end
                    end
`endif
                    default: go_err = 1'b1;
                endcase
            end

            SHOW: begin
                if (scan_done) state_nxt = ret;
            end

            HOLD: begin
                if (accept) begin
                    if (is_digit) begin
                        cur_nxt  = cmd_w;
                        a_nxt    = '0;
                        show_val = cmd_w;
                        show_ret = ENTER_A;
                        go_show  = 1'b1;
                    end else if (is_op) begin
                        if (!op_ok) begin
                            go_err = 1'b1;
                        end else begin
                            // Chain: the held result becomes operand A.
                            a_nxt    = acc;
                            op_nxt   = cmd;
                            cur_nxt  = '0;
                            show_val = '0;
                            show_ret = ENTER_B;
                            go_show  = 1'b1;
                        end
                    end else begin
                        show_val = acc;
                        go_show  = 1'b1;
                    end
                end
            end

            ERRO:    state_nxt = ERRO;
            default: state_nxt = ERRO;
        endcase

        if (go_err) begin
            state_nxt = ERRO;
        end else if (go_show) begin
            state_nxt = SHOW;
            shown_nxt = show_val;
            ret_nxt   = show_ret;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ENTER_A;
            ret   <= ENTER_A;
            cur   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            shown <= '0;
            op    <= CMD_ADD;
        end else begin
            state <= state_nxt;
            ret   <= ret_nxt;
            cur   <= cur_nxt;
            a_reg <= a_nxt;
            b_reg <= b_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            shown <= shown_nxt;
            op    <= op_nxt;
        end
    end

    calc_digit_scan #(
        .NDIG  (NDIG),
        .WIDTH (WIDTH)
    ) u_scan (
        .clock      (clock),
        .reset      (reset),
        .load       (scan_load),
        .value      (shown),
        .data       (data),
        .pos        (pos),
        .disp_valid (disp_valid),
        .done       (scan_done)
    );

endmodule

// File: tb/tb_calc_ndig.sv
// tb_calc_ndig: directed test of calc_ndig with NDIG=8, WIDTH=30.
// Each keypress waits for ready, sends one command and collects the scan
// that follows, reassembling the decimal value and the busy lead-in time.
module tb_calc_ndig;
    import calc_pkg::*;

    localparam int NDIG  = 8;
    localparam int WIDTH = 30;
    localparam int PW    = $clog2(NDIG);

    logic          clock;
    logic          reset;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [1:0]    status;
    logic [3:0]    data;
    logic [PW-1:0] pos;
    logic          disp_valid;
    logic [2:0]    EA;

    int            checks;
    int            errors;
    longint        scan_val;
    int            scan_nd;
    int            pre_busy;
    int            pos_bad;
    logic [1:0]    first_st;
    logic          disp_seen;

    calc_ndig #(.NDIG(NDIG), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .status     (status),
        .data       (data),
        .pos        (pos),
        .disp_valid (disp_valid),
        .EA         (EA)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Send one command when ready and capture the scan that follows.
    task automatic key(input logic [3:0] c);
        int     g;
        longint m;
        scan_val = 0;
        scan_nd  = 0;
        pre_busy = 0;
        pos_bad  = 0;
        first_st = 2'b11;
        m        = 1;
        g        = 0;
        @(negedge clock);
        while (status != ST_READY && g < 50) begin
            @(negedge clock);
            g++;
        end
        if (status == ST_READY) begin
            cmd       = c;
            cmd_valid = 1'b1;
            @(posedge clock);
            #1 cmd_valid = 1'b0;
            g = 0;
            while (g < 400) begin
                @(negedge clock);
                g++;
                if (g == 1) first_st = status;
                if (disp_valid) begin
                    if (int'(pos) != scan_nd) pos_bad++;
                    scan_val = scan_val + longint'(data) * m;
                    m        = m * 10;
                    scan_nd++;
                end else if (status != ST_BUSY) begin
                    break;
                end else if (scan_nd == 0) begin
                    pre_busy++;
                end
            end
            if (g >= 400) chk("key_timeout", g, 0);
        end
    endtask

    task automatic kv(input string tag, input logic [3:0] c, input longint e);
        key(c);
        chk(tag, scan_val, e);
        chk({tag, "_ndig"}, scan_nd, NDIG);
        chk({tag, "_pos"}, pos_bad, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        cmd       = 4'd0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_status", status, ST_READY);
        chk("rst_disp", disp_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_pos", pos, 0);
        chk("rst_ea", EA, ENTER_A);
        reset = 1'b0;

        // 12 + 34 = 46, digit timing: one busy cycle, then NDIG digits.
        kv("d1", 4'd1, 1);
        chk("d1_first_busy", first_st, ST_BUSY);
        chk("d1_lead", pre_busy, 1);
        kv("d12", 4'd2, 12);
        kv("add", CMD_ADD, 0);
        chk("add_ea", EA, ENTER_B);
        kv("d3", 4'd3, 3);
        kv("d34", 4'd4, 34);
        kv("eq46", CMD_EQ, 46);
        chk("eq46_lead", pre_busy, 2);
        chk("eq46_ea", EA, HOLD);
        chk("eq46_status", status, ST_READY);

        // From HOLD: 7 * 6; lead = scan setup + min(7,6)+1 calc cycles.
        kv("h7", 4'd7, 7);
        chk("h7_ea", EA, ENTER_A);
        kv("mul", CMD_MUL, 0);
        kv("d6", 4'd6, 6);
        kv("eq42", CMD_EQ, 42);
        chk("eq42_lead", pre_busy, 8);

        // Chaining 42 - 2.
        kv("sub", CMD_SUB, 0);
        kv("d2", 4'd2, 2);
        kv("eq40", CMD_EQ, 40);
        chk("eq40_lead", pre_busy, 2);

        // Backspace and full-entry limit.
        kv("e1", 4'd1, 1);
        kv("e12", 4'd2, 12);
        kv("e123", 4'd3, 123);
        kv("bksp", CMD_BKSP, 12);
        for (int d = 3; d <= 8; d++) key(4'(d));
        chk("full8", scan_val, 12345678);
        kv("ninth", 4'd9, 12345678);
        kv("eq_in_a", CMD_EQ, 12345678);
        chk("eq_in_a_ea", EA, ENTER_A);

        // 5 - 9 underflows; error state is sticky until reset.
        do_reset();
        key(4'd5); key(CMD_SUB); key(4'd9); key(CMD_EQ);
        chk("under_status", status, ST_ERR);
        chk("under_ea", EA, ERRO);
        chk("under_noscan", scan_nd, 0);
        disp_seen = 1'b0;
        @(negedge clock);
        cmd = 4'd1;
        cmd_valid = 1'b1;
        repeat (12) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            disp_seen = disp_seen | disp_valid;
        end
        chk("erro_ignore_status", status, ST_ERR);
        chk("erro_ignore_disp", disp_seen, 0);
        do_reset();
        chk("erro_rst_status", status, ST_READY);
        chk("erro_rst_ea", EA, ENTER_A);

        // 99999999 * 2 overflows.
        for (int i = 0; i < 7; i++) key(4'd9);
        kv("nines", 4'd9, 99999999);
        key(CMD_MUL); key(4'd2); key(CMD_EQ);
        chk("ovf_status", status, ST_ERR);

        // Divide by zero (or divide absent) ends in error.
        do_reset();
        key(4'd8); key(CMD_DIV); key(4'd0); key(CMD_EQ);
        chk("div0_status", status, ST_ERR);

        do_reset();
`ifdef CALC_DIV_EN
        key(4'd9); key(CMD_DIV); key(4'd2);
        kv("div9_2", CMD_EQ, 4);
        chk("div_lead", pre_busy, 6);
`else
        key(4'd9); key(CMD_DIV);
        chk("nodiv_status", status, ST_ERR);
`endif

        // Reset in the middle of a 99 * 50 multiply loop.
        do_reset();
        key(4'd9); key(4'd9); key(CMD_MUL); key(4'd5); key(4'd0);
        @(negedge clock);
        cmd = CMD_EQ;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        chk("mulloop_status", status, ST_BUSY);
        chk("mulloop_ea", EA, CALC);
        #2 reset = 1'b1;
        #1;
        chk("midcalc_rst_disp", disp_valid, 0);
        chk("midcalc_rst_ea", EA, ENTER_A);
        @(negedge clock);
        reset = 1'b0;
        kv("after_calc_rst", 4'd3, 3);

        // Reset in the middle of a scan drops disp_valid at once.
        @(negedge clock);
        cmd = 4'd4;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clock);
        chk("midscan_disp", disp_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("midscan_rst_disp", disp_valid, 0);
        chk("midscan_rst_status", status, ST_READY);
        @(negedge clock);
        reset = 1'b0;
        kv("after_scan_rst", 4'd5, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
